// File: rtl/irig_frame_sequencer.sv
// IRIG-B frame sequencer: aligns on MARK-MARK, walks positions 0..99, checks markers,
// assembles BCD time into shadow registers and publishes it with lock status.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_HUNT  | no alignment, waiting for a MARK
// ST_SYNC  | previous symbol was a MARK; another MARK starts a frame (Pr)
// ST_FRAME | inside a frame, pos_q is the position of the next symbol
module irig_frame_sequencer #(
  parameter int SYM_TIMEOUT = 150000,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk_10mhz,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic [1:0] sym,
  output logic       frame_valid,
  output logic [6:0] sec_bcd,
  output logic [6:0] min_bcd,
  output logic [5:0] hour_bcd,
  output logic [9:0] day_bcd,
  output logic       locked,
  output logic       pps_en,
  output logic [7:0] err_cnt
);

  localparam int TW = $clog2(SYM_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(SYM_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(SYM_TIMEOUT);
  localparam logic [3:0]    LF      = 4'(LOCK_FRAMES);

  localparam logic [1:0] SYM_D1   = 2'b01;
  localparam logic [1:0] SYM_MARK = 2'b10;

  typedef enum logic [1:0] {ST_HUNT, ST_SYNC, ST_FRAME} state_t;

  state_t        state_q, state_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic [29:0]   shadow_q, shadow_d;
  logic [29:0]   time_q, time_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    good_q, good_d;
  logic [7:0]    err_q, err_d;
  logic          locked_q, locked_d;
  logic          fv_q, fv_d;

  logic       is_mark, marker_slot, sym_ok, cap_hit, to_hit;
  logic       err_inc, lose, frame_done;
  logic [4:0] cap_idx;

  // Field layout in shadow/time: sec[6:0], min[13:7], hour[19:14], day[29:20].
  always_comb begin
    cap_hit = 1'b1;
    cap_idx = 5'd0;
    case ({tens_q, ones_q})
      8'h01: cap_idx = 5'd0;
      8'h02: cap_idx = 5'd1;
      8'h03: cap_idx = 5'd2;
      8'h04: cap_idx = 5'd3;
      8'h06: cap_idx = 5'd4;
      8'h07: cap_idx = 5'd5;
      8'h08: cap_idx = 5'd6;
      8'h10: cap_idx = 5'd7;
      8'h11: cap_idx = 5'd8;
      8'h12: cap_idx = 5'd9;
      8'h13: cap_idx = 5'd10;
      8'h15: cap_idx = 5'd11;
      8'h16: cap_idx = 5'd12;
      8'h17: cap_idx = 5'd13;
      8'h20: cap_idx = 5'd14;
      8'h21: cap_idx = 5'd15;
      8'h22: cap_idx = 5'd16;
      8'h23: cap_idx = 5'd17;
      8'h25: cap_idx = 5'd18;
      8'h26: cap_idx = 5'd19;
      8'h30: cap_idx = 5'd20;
      8'h31: cap_idx = 5'd21;
      8'h32: cap_idx = 5'd22;
      8'h33: cap_idx = 5'd23;
      8'h35: cap_idx = 5'd24;
      8'h36: cap_idx = 5'd25;
      8'h37: cap_idx = 5'd26;
      8'h38: cap_idx = 5'd27;
      8'h40: cap_idx = 5'd28;
      8'h41: cap_idx = 5'd29;
      default: cap_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    shadow_d   = shadow_q;
    time_d     = time_q;
    to_cnt_d   = to_cnt_q;
    good_d     = good_q;
    err_d      = err_q;
    locked_d   = locked_q;
    fv_d       = 1'b0;
    err_inc    = 1'b0;
    lose       = 1'b0;
    frame_done = 1'b0;

    is_mark     = (sym == SYM_MARK);
    marker_slot = (ones_q == 4'd9) || ({tens_q, ones_q} == 8'h00);
    sym_ok      = marker_slot ? is_mark : !sym[1];
    // A symbol arriving on the timeout cycle suppresses the timeout.
    to_hit      = !sym_valid && (to_cnt_q == TO_LAST);

    if (sym_valid) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    if (sym_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (is_mark) state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (is_mark) begin
            state_d = ST_FRAME;
            ones_d  = 4'd1;
            tens_d  = 4'd0;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_FRAME: begin
          if (!sym_ok) begin
            state_d = ST_HUNT;
            err_inc = 1'b1;
            lose    = 1'b1;
          end else begin
            if (cap_hit) shadow_d[cap_idx] = (sym == SYM_D1);
            if ({tens_q, ones_q} == 8'h99) begin
              state_d    = ST_SYNC;
              ones_d     = 4'd0;
              tens_d     = 4'd0;
              frame_done = 1'b1;
            end else if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              tens_d = tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (to_hit) begin
      state_d = ST_HUNT;
      lose    = 1'b1;
      err_inc = (state_q == ST_FRAME);
    end

    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;

    if (frame_done) begin
      time_d = shadow_q;
      fv_d   = 1'b1;
    end

    if (lose) begin
      good_d   = 4'd0;
      locked_d = 1'b0;
    end else begin
      if (frame_done && good_q != LF) good_d = good_q + 4'd1;
      if (good_q == LF) locked_d = 1'b1;
    end
  end

  always_ff @(posedge clk_10mhz) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      ones_q   <= 4'd0;
      tens_q   <= 4'd0;
      shadow_q <= '0;
      time_q   <= '0;
      to_cnt_q <= '0;
      good_q   <= 4'd0;
      err_q    <= 8'd0;
      locked_q <= 1'b0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      tens_q   <= tens_d;
      shadow_q <= shadow_d;
      time_q   <= time_d;
      to_cnt_q <= to_cnt_d;
      good_q   <= good_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      fv_q     <= fv_d;
    end
  end

  assign frame_valid = fv_q;
  assign sec_bcd     = time_q[6:0];
  assign min_bcd     = time_q[13:7];
  assign hour_bcd    = time_q[19:14];
  assign day_bcd     = time_q[29:20];
  assign locked      = locked_q;
  assign pps_en      = locked_q;
  assign err_cnt     = err_q;

endmodule
